regfile_scoreboard: RTL and testbench

// - Consumer end of the writeback interface: takes the per-cycle register write from writeback (valid/dst/data/wen).
// - Commits that write into the 32-entry integer register file.
// - Serves the two decode read ports (ra1/ra2 -> rd1/rd2).
// - Tracks in-flight destination writes with a per-register pending counter so decode can stall on RAW hazards.

---
 rtl/regfile_scoreboard.sv | 120 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32-entry integer register file with a per-register
// pending-write scoreboard for RAW hazard stalls at decode.
// Optional feature macro: REGFILE_BYPASS_EN (write-through of the commit
// cycle's writeback data and busy release onto the decode read ports).
//
// Handshake: issue_valid/issue_ready follow valid/ready semantics. An issue is
// recorded only in a cycle where both are 1. issue_ready depends only on
// issue_dst and current state, never on issue_valid. A writeback in the same
// cycle does not raise issue_ready. The writeback side has no back-pressure:
// wb_valid & wb_wen is always accepted.
module regfile_scoreboard #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_dst,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic            wb_wen,
  input  logic [AW-1:0]   wb_dst,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            flush,
  output logic            sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] cnt_q  [NREG];
  logic [CNT_W-1:0] cnt_d  [NREG];
  logic             sb_err_q, sb_err_d;

  logic inc, commit, same_reg, underflow;

  // Issue acceptance and retire qualification, all from pre-edge state.
  assign issue_ready = (issue_dst == '0) | (cnt_q[issue_dst] != CNT_MAX);
  assign inc         = issue_valid & issue_ready & (issue_dst != '0);
  assign commit      = wb_valid & wb_wen & (wb_dst != '0);
  assign same_reg    = inc & commit & (issue_dst == wb_dst);
  assign underflow   = commit & (cnt_q[wb_dst] == '0);
  assign sb_err      = sb_err_q;

  // Next-state: register commit, counter inc/dec/flush, sticky error.
  always_comb begin
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    if (commit) regs_d[wb_dst] = wb_data;
    if (flush) begin
      for (int i = 0; i < NREG; i++) cnt_d[i] = '0;
    end else begin
      if (underflow) sb_err_d = 1'b1;
      // Matching inc and dec on one register cancel out.
      if (!same_reg) begin
        if (inc) cnt_d[issue_dst] = cnt_q[issue_dst] + CNT_ONE;
        if (commit && (cnt_q[wb_dst] != '0)) cnt_d[wb_dst] = cnt_q[wb_dst] - CNT_ONE;
      end
    end
  end

  // State registers; async active-low reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  // Read port 1: x0 reads 0 and is never busy.
  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    if (ra1 != '0) begin
      rd1   = regs_q[ra1];
      busy1 = (cnt_q[ra1] != '0);
`ifdef REGFILE_BYPASS_EN
      if (commit && (wb_dst == ra1)) begin
        rd1 = wb_data;
        if (cnt_q[ra1] == CNT_ONE) busy1 = 1'b0;
      end
`endif
    end
  end

  // Read port 2: identical to port 1.
  always_comb begin
    rd2   = '0;
    busy2 = 1'b0;
    if (ra2 != '0) begin
      rd2   = regs_q[ra2];
      busy2 = (cnt_q[ra2] != '0);
`ifdef REGFILE_BYPASS_EN
      if (commit && (wb_dst == ra2)) begin
        rd2 = wb_data;
        if (cnt_q[ra2] == CNT_ONE) busy2 = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic,
// checked against an array/integer model of the register file and counters.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_dst;
  logic        issue_ready;
  logic        wb_valid;
  logic        wb_wen;
  logic [4:0]  wb_dst;
  logic [63:0] wb_data;
  logic [4:0]  ra1, ra2;
  logic [63:0] rd1, rd2;
  logic        busy1, busy2;
  logic        flush;
  logic        sb_err;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [63:0] m_reg [32];
  int          m_cnt [32];
  bit          m_err;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_dst(wb_dst), .wb_data(wb_data),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .flush(flush), .sb_err(sb_err)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic bit m_commit();
    return wb_valid && wb_wen && (wb_dst != 0);
  endfunction

  function automatic bit m_ready();
    return (issue_dst == 0) || (m_cnt[issue_dst] < 3);
  endfunction

  function automatic logic [63:0] m_rd(input logic [4:0] ra);
    if (ra == 0) return '0;
    if (BYP && m_commit() && wb_dst == ra) return wb_data;
    return m_reg[ra];
  endfunction

  function automatic bit m_busy(input logic [4:0] ra);
    if (ra == 0 || m_cnt[ra] == 0) return 1'b0;
    if (BYP && m_commit() && wb_dst == ra && m_cnt[ra] == 1) return 1'b0;
    return 1'b1;
  endfunction

  // Apply one clock edge's worth of architectural rules to the model.
  task automatic model_edge();
    bit do_inc, do_com, under;
    do_inc = issue_valid && m_ready() && (issue_dst != 0);
    do_com = m_commit();
    under  = do_com && (m_cnt[wb_dst] == 0);
    if (do_com) m_reg[wb_dst] = wb_data;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      if (under) m_err = 1'b1;
      if (do_inc) m_cnt[issue_dst] = m_cnt[issue_dst] + 1;
      if (do_com && m_cnt[wb_dst] > 0) m_cnt[wb_dst] = m_cnt[wb_dst] - 1;
    end
  endtask

  task automatic check_all();
    chk("issue_ready", issue_ready, m_ready());
    chk("rd1", rd1, m_rd(ra1));
    chk("rd2", rd2, m_rd(ra2));
    chk("busy1", busy1, m_busy(ra1));
    chk("busy2", busy2, m_busy(ra2));
    chk("sb_err", sb_err, m_err);
  endtask

  // Check pre-edge outputs, clock once, update the model, return at negedge.
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_dst = 0;
    wb_valid = 0; wb_wen = 0; wb_dst = 0; wb_data = '0;
    flush = 0;
  endtask

  logic [63:0] rdata;

  initial begin
    // Reset
    idle_inputs();
    ra1 = 5; ra2 = 0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd1", rd1, 64'h0);
    chk("rst_rd2", rd2, 64'h0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
    chk("rst_ready", issue_ready, 1'b1);
    chk("rst_sb_err", sb_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Issue x5 then retire two cycles later
    issue_valid = 1; issue_dst = 5; ra1 = 5;
    tick();
    issue_valid = 0;
    #1 chk("iss_busy1_a", busy1, 1'b1);
    tick();
    #1 chk("iss_busy1_b", busy1, 1'b1);
    tick();
    wb_valid = 1; wb_wen = 1; wb_dst = 5; wb_data = 64'hDEAD_BEEF;
    #1;
    chk("commit_rd1", rd1, BYP ? 64'hDEAD_BEEF : 64'h0);
    chk("commit_busy1", busy1, BYP ? 1'b0 : 1'b1);
    tick();
    idle_inputs();
    #1;
    chk("after_rd1", rd1, 64'hDEAD_BEEF);
    chk("after_busy1", busy1, 1'b0);
    tick();

    // Saturation on x7
    issue_valid = 1; issue_dst = 7; ra2 = 7;
    repeat (3) tick();
    #1 chk("sat_ready0", issue_ready, 1'b0);
    tick();  // fourth issue must be dropped
    issue_valid = 0;
    wb_valid = 1; wb_wen = 1; wb_dst = 7; wb_data = 64'h77;
    #1 chk("sat_wb_no_raise", issue_ready, 1'b0);
    tick();
    idle_inputs(); issue_dst = 7;
    #1 chk("sat_ready1", issue_ready, 1'b1);
    issue_valid = 1; wb_valid = 1; wb_wen = 1; wb_dst = 7; wb_data = 64'h78;
    tick();  // same-cycle inc+dec: count stays at 2
    idle_inputs(); issue_dst = 7;
    #1 chk("same_cyc_ready", issue_ready, 1'b1);
    issue_valid = 1;
    tick();
    issue_valid = 0;
    #1 chk("sat_again_ready0", issue_ready, 1'b0);
    tick();

    // x0 is never written or tracked
    issue_valid = 1; issue_dst = 0; ra1 = 0;
    wb_valid = 1; wb_wen = 1; wb_dst = 0; wb_data = 64'h1234;
    #1 chk("x0_ready", issue_ready, 1'b1);
    tick();
    idle_inputs();
    #1;
    chk("x0_rd1", rd1, 64'h0);
    chk("x0_busy1", busy1, 1'b0);
    tick();

    // Flush with an untracked commit in the same cycle
    issue_valid = 1; issue_dst = 3; ra1 = 3;
    repeat (2) tick();
    issue_valid = 0;
    #1 chk("pre_flush_busy", busy1, 1'b1);
    flush = 1; wb_valid = 1; wb_wen = 1; wb_dst = 12; wb_data = 64'hC0FFEE;
    tick();
    idle_inputs(); ra2 = 12;
    #1;
    chk("flush_busy", busy1, 1'b0);
    chk("flush_no_err", sb_err, 1'b0);
    chk("flush_commit", rd2, 64'hC0FFEE);
    tick();

    // Underflow
    rdata = {$urandom, $urandom};
    wb_valid = 1; wb_wen = 1; wb_dst = 9; wb_data = rdata;
    tick();
    idle_inputs(); ra1 = 9;
    #1;
    chk("uf_err", sb_err, 1'b1);
    chk("uf_data", rd1, rdata);
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_dst   = 5'($urandom_range(0, 7));
      wb_valid    = 1'($urandom_range(0, 1));
      wb_wen      = ($urandom_range(0, 3) != 0);
      wb_dst      = 5'($urandom_range(0, 7));
      wb_data     = {$urandom, $urandom};
      ra1         = 5'($urandom_range(0, 7));
      ra2         = 5'($urandom_range(0, 31));
      flush       = ($urandom_range(0, 19) == 0);
      tick();
    end

    // Async reset mid-stream, between clock edges
    issue_valid = 1; issue_dst = 4; ra1 = 9; ra2 = 4;
    #2 reset = 1'b0;
    #1;
    chk("arst_rd1", rd1, 64'h0);
    chk("arst_busy2", busy2, 1'b0);
    chk("arst_err", sb_err, 1'b0);
    chk("arst_ready", issue_ready, 1'b1);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
